// File: rtl/serial_tx.sv
// serial_tx: frame transmitter producing preamble, MSB-first data and optional
// even parity, one bit per clock, with registered outputs and a done pulse.
module serial_tx #(
    parameter int                 WIDTH     = 8,
    parameter int                 PRE_LEN   = 4,
    parameter logic [PRE_LEN-1:0] PREAMBLE  = 4'b1101,
    parameter int                 PARITY_EN = 1
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             X,
    output logic             X_valid,
    output logic             busy,
    output logic             done
);

    localparam int MAXL = (PRE_LEN > WIDTH) ? PRE_LEN : WIDTH;
    localparam int CW   = $clog2(MAXL + 1);
    localparam logic [CW-1:0] PRE_TOP = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] DAT_TOP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        PAR
    } state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [WIDTH-1:0]   sh, sh_n;
    logic               par, par_n;
    logic               fin, fin_n;
    logic               x_c, v_c;
    logic [PRE_LEN-1:0] pre_sh;

    // State, counter, data and the registered output stage.
    // Outputs trail the state by one edge; busy gates acceptance so the
    // edge that ends the last frame bit cannot start a new frame.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            sh      <= '0;
            par     <= 1'b0;
            fin     <= 1'b0;
            X       <= 1'b0;
            X_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sh      <= sh_n;
            par     <= par_n;
            fin     <= fin_n;
            X       <= x_c;
            X_valid <= v_c;
            busy    <= v_c;
            done    <= fin;
        end
    end

    // Next-state, datapath update and the bit to present next cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        par_n   = par;
        fin_n   = 1'b0;
        x_c     = 1'b0;
        v_c     = 1'b0;
        pre_sh  = PREAMBLE >> cnt;
        unique case (state)
            IDLE: begin
                if (start && !busy) begin
                    sh_n    = din;
                    par_n   = ^din;
                    cnt_n   = PRE_TOP;
                    state_n = PRE;
                end
            end
            PRE: begin
                x_c = pre_sh[0];
                v_c = 1'b1;
                if (cnt == '0) begin
                    cnt_n   = DAT_TOP;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                x_c  = sh[WIDTH-1];
                v_c  = 1'b1;
                sh_n = sh << 1;
                if (cnt == '0) begin
                    if (PARITY_EN != 0) begin
                        state_n = PAR;
                    end else begin
                        state_n = IDLE;
                        fin_n   = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            PAR: begin
                x_c     = par;
                v_c     = 1'b1;
                state_n = IDLE;
                fin_n   = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: drives serial_tx with directed and random frames and compares
// the serial stream against a frame built from preamble/data/parity rules.
module tb_serial_tx;

    logic       Clk = 1'b0;
    logic       reset;
    logic       start0, start1;
    logic [7:0] din0;
    logic [3:0] din1;
    logic       X0, Xv0, busy0, done0;
    logic       X1, Xv1, busy1, done1;

    int total = 0;
    int bad   = 0;
    bit exp_q[$];
    logic [3:0] pre = 4'b1101;

    always #5 Clk = ~Clk;

    serial_tx u0 (
        .Clk(Clk), .reset(reset), .start(start0), .din(din0),
        .X(X0), .X_valid(Xv0), .busy(busy0), .done(done0)
    );

    serial_tx #(.WIDTH(4), .PARITY_EN(0)) u1 (
        .Clk(Clk), .reset(reset), .start(start1), .din(din1),
        .X(X1), .X_valid(Xv1), .busy(busy1), .done(done1)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected frame: preamble MSB first, data MSB first, even parity bit.
    function automatic void build(input int w, input logic [31:0] d,
                                  input bit pe);
        logic [31:0] m;
        exp_q = {};
        for (int i = 3; i >= 0; i--) exp_q.push_back(pre[i]);
        for (int j = w - 1; j >= 0; j--) exp_q.push_back(d[j]);
        m = d & ((32'd1 << w) - 32'd1);
        if (pe) exp_q.push_back(($countones(m) % 2) == 1);
    endfunction

    // Caller has start0/din0 set up for the accepting edge.
    task automatic run_frame(input bit noise, input bit chain,
                             input logic [7:0] nxt);
        build(8, {24'd0, din0}, 1'b1);
        tick();
        start0 = 1'b0;
        chk("idle_after_accept_busy", busy0, 0);
        chk("idle_after_accept_valid", Xv0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (noise) begin
                start0 = 1'($urandom);
                din0   = 8'($urandom);
            end
            tick();
            chk($sformatf("bit%0d_x", i), X0, exp_q[i]);
            chk($sformatf("bit%0d_valid", i), Xv0, 1);
            chk($sformatf("bit%0d_busy", i), busy0, 1);
            chk($sformatf("bit%0d_done", i), done0, 0);
        end
        start0 = 1'b0;
        tick();
        chk("done_pulse", done0, 1);
        chk("done_busy", busy0, 0);
        chk("done_valid", Xv0, 0);
        if (chain) begin
            start0 = 1'b1;
            din0   = nxt;
        end else begin
            tick();
            chk("done_one_cycle", done0, 0);
            chk("no_extra_frame", Xv0, 0);
            tick();
            chk("still_idle", Xv0, 0);
        end
    endtask

    initial begin
        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        din0   = 8'h00;
        din1   = 4'h0;
        tick();
        tick();
        chk("rst_x", X0, 0);
        chk("rst_valid", Xv0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_u1", {X1, Xv1, busy1, done1}, 0);
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_done", done0, 0);

        start0 = 1'b1;
        din0   = 8'hA5;
        run_frame(1'b0, 1'b1, 8'h01);
        run_frame(1'b0, 1'b0, 8'h00);

        start0 = 1'b1;
        din0   = 8'h3C;
        run_frame(1'b1, 1'b0, 8'h00);

        for (int n = 0; n < 6; n++) begin
            start0 = 1'b1;
            din0   = 8'($urandom);
            run_frame(n[0], n == 2, 8'($urandom));
            if (n == 2) run_frame(1'b0, 1'b0, 8'h00);
        end

        start0 = 1'b1;
        din0   = 8'h5A;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("abort_x", X0, 0);
        chk("abort_valid", Xv0, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("abort_no_done", done0, 0);
            chk("abort_no_valid", Xv0, 0);
        end
        start0 = 1'b1;
        din0   = 8'($urandom);
        run_frame(1'b0, 1'b0, 8'h00);

        build(4, 32'hF, 1'b0);
        start1 = 1'b1;
        din1   = 4'hF;
        tick();
        start1 = 1'b0;
        chk("u1_idle_after_accept", Xv1, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            tick();
            chk($sformatf("u1_bit%0d_x", i), X1, exp_q[i]);
            chk($sformatf("u1_bit%0d_valid", i), Xv1, 1);
            chk($sformatf("u1_bit%0d_done", i), done1, 0);
        end
        tick();
        chk("u1_done", done1, 1);
        chk("u1_done_busy", busy1, 0);
        tick();
        chk("u1_done_once", done1, 0);
        chk("u0_quiet", Xv0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
